// File: rtl/tx_pkg.sv
// Shared types and constants for the TX symbol mapper.
// Scrambler constants are used only when TX_MAPPER_SCRAMBLER_EN is defined.
package tx_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK,
    MODE_QPSK,
    MODE_QAM16,
    MODE_RSVD
  } tx_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_MAP
  } tx_state_t;

  localparam logic [6:0] SCR_SEED = 7'h7F;
  // x^7 + x^4 + 1: feedback from lfsr[6] and lfsr[3]
  localparam logic [6:0] SCR_TAPS = 7'h48;

  function automatic logic [2:0] bits_per_sym(input tx_mode_t m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QAM16: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/tx_scrambler.sv
// x^7+x^4+1 additive scrambler producing up to 4 bits per cycle.
// s[0] applies to the first bit consumed; reseed takes effect in the same cycle.
module tx_scrambler
  import tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       reseed,
  input  logic [2:0] nbits,
  output logic [3:0] s
);

  logic [6:0] lfsr_q;
  logic [6:0] w0, w1, w2, w3, w4;
  logic [6:0] nxt;

  function automatic logic [6:0] adv1(input logic [6:0] x);
    return {x[5:0], ^(x & SCR_TAPS)};
  endfunction

  always_comb begin
    w0 = reseed ? SCR_SEED : lfsr_q;
    w1 = adv1(w0);
    w2 = adv1(w1);
    w3 = adv1(w2);
    w4 = adv1(w3);
    s  = {^(w3 & SCR_TAPS), ^(w2 & SCR_TAPS),
          ^(w1 & SCR_TAPS), ^(w0 & SCR_TAPS)};
    nxt = w0;
    if (step) begin
      case (nbits)
        3'd1:    nxt = w1;
        3'd2:    nxt = w2;
        3'd3:    nxt = w3;
        3'd4:    nxt = w4;
        default: nxt = w0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SCR_SEED;
    else        lfsr_q <= nxt;
  end

endmodule

// File: rtl/tx_symbol_mapper.sv
// AXIS byte stream to BPSK/QPSK/16QAM I/Q symbols, each held SPS beats.
// Define TX_MAPPER_SCRAMBLER_EN to scramble data bits before mapping.
module tx_symbol_mapper
  import tx_pkg::*;
#(
  parameter int IN_BYTES  = 1,
  parameter int OUT_WIDTH = 12,
  parameter int AMP       = 1447,
  parameter int SPS       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [2*OUT_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int W  = 8 * IN_BYTES;
  localparam int CW = $clog2(W + 1);
  localparam int LO = AMP / 3;
  localparam logic [OUT_WIDTH-1:0] P_AMP = OUT_WIDTH'(AMP);
  localparam logic [OUT_WIDTH-1:0] N_AMP = OUT_WIDTH'(-AMP);
  localparam logic [OUT_WIDTH-1:0] P_LO  = OUT_WIDTH'(LO);
  localparam logic [OUT_WIDTH-1:0] N_LO  = OUT_WIDTH'(-LO);
  localparam logic [3:0] HOLD_MAX = 4'(SPS - 1);

  if (AMP >= 2**(OUT_WIDTH-1) || SPS < 1 || SPS > 16) begin : g_bad_cfg
    $fatal(1, "tx_symbol_mapper: AMP or SPS out of range");
  end

  tx_state_t              state_q, nxt;
  logic [W-1:0]           word_q;
  logic [CW-1:0]          cnt_q;
  tx_mode_t               mode_q;
  logic                   last_q;
  logic [3:0]             hold_q;
  logic                   sym_last_q;

  tx_mode_t               in_mode, src_mode;
  logic [W-1:0]           src_bits;
  logic [CW-1:0]          src_cnt;
  logic                   src_last;
  logic                   accept, adv, more, load, last_sym;
  logic [2:0]             k;
  logic [3:0]             sym;
  logic [OUT_WIDTH-1:0]   i_val, q_val;

  function automatic logic [CW-1:0] nsym(input tx_mode_t m);
    case (m)
      MODE_BPSK:  return CW'(W);
      MODE_QAM16: return CW'(W / 4);
      default:    return CW'(W / 2);
    endcase
  endfunction

  function automatic logic [OUT_WIDTH-1:0] lvl2(input logic b);
    return b ? N_AMP : P_AMP;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] gray4(input logic [1:0] b);
    case (b)
      2'b00:   return P_AMP;
      2'b01:   return P_LO;
      2'b11:   return N_LO;
      default: return N_AMP;
    endcase
  endfunction

  assign in_mode = tx_mode_t'(mode);

`ifdef TX_MAPPER_SCRAMBLER_EN
  logic [3:0] scr;

  tx_scrambler u_scr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (load),
    .reseed (out_valid && out_ready && out_last),
    .nbits  (k),
    .s      (scr)
  );

  assign sym = src_bits[3:0] ^ scr;
`else
  assign sym = src_bits[3:0];
`endif

  // A word being accepted can feed the output in the same cycle.
  always_comb begin
    accept   = in_valid && in_ready;
    adv      = !out_valid || out_ready;
    more     = out_valid && (hold_q != HOLD_MAX);
    src_mode = accept ? in_mode : mode_q;
    src_bits = accept ? in_data : word_q;
    src_last = accept ? in_last : last_q;
    src_cnt  = accept ? nsym(in_mode) : cnt_q;
    k        = bits_per_sym(src_mode);
    load     = adv && !more && (accept || state_q == ST_MAP);
    last_sym = src_last && (src_cnt == CW'(1));
    case (src_mode)
      MODE_BPSK: begin
        i_val = lvl2(sym[0]);
        q_val = '0;
      end
      MODE_QAM16: begin
        i_val = gray4(sym[1:0]);
        q_val = gray4(sym[3:2]);
      end
      default: begin
        i_val = lvl2(sym[0]);
        q_val = lvl2(sym[1]);
      end
    endcase
    nxt = state_q;
    if (load)        nxt = (src_cnt == CW'(1)) ? ST_IDLE : ST_MAP;
    else if (accept) nxt = ST_MAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_BPSK;
      last_q     <= 1'b0;
      hold_q     <= '0;
      sym_last_q <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q  <= nxt;
      in_ready <= (nxt == ST_IDLE);
      if (load) begin
        word_q <= src_bits >> k;
        cnt_q  <= src_cnt - CW'(1);
        mode_q <= src_mode;
        last_q <= src_last;
      end else if (accept) begin
        word_q <= in_data;
        cnt_q  <= nsym(in_mode);
        mode_q <= in_mode;
        last_q <= in_last;
      end
      if (adv) begin
        if (more) begin
          hold_q   <= hold_q + 4'd1;
          out_last <= sym_last_q && (hold_q + 4'd1 == HOLD_MAX);
        end else if (load) begin
          out_valid  <= 1'b1;
          out_data   <= {i_val, q_val};
          hold_q     <= '0;
          sym_last_q <= last_sym;
          out_last   <= last_sym && (HOLD_MAX == 4'd0);
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          hold_q    <= '0;
        end
      end
    end
  end

endmodule
